mips_reg_file: RTL and testbench

- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU: its two read ports drive ALU operand_1 and operand_2.
- Write-back (ALU result or load data) returns through the single write port.
- Register $0 is hardwired to zero; a third read-only debug port exists for bench and board observation.

---
 rtl/mips_reg_file_if.sv | 27 ++
 rtl/mips_reg_file.sv | 87 ++++++++
 tb/tb_mips_reg_file.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_reg_file_if.sv
// Bus bundle for the MIPS register file: two ALU read ports,
// one write-back port, a debug read port and the write counter.
interface mips_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       wr_count;

    modport master (
        output rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, dbg_addr,
        input  rd_data_1, rd_data_2, dbg_data, wr_count
    );

    modport slave (
        input  rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, dbg_addr,
        output rd_data_1, rd_data_2, dbg_data, wr_count
    );
endinterface

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS register file, $0 hardwired to zero, async active-high reset.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding.
module mips_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    mips_reg_file_if.slave   bus
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;
    logic              wr_hit;

    // A write commits only when enabled and not aimed at $0.
    assign wr_hit = bus.wr_en && (bus.wr_addr != '0);

    // Next-state: update the addressed register and bump the write counter.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        wr_count_d = wr_count_q;
        if (wr_hit) begin
            regs_d[bus.wr_addr] = bus.wr_data;
            wr_count_d          = wr_count_q + 16'd1;
        end
    end

    // State registers; reset clears everything and masks a coincident write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            regs_q[0]  <= '0;
            wr_count_q <= wr_count_d;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              fwd_hit,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data
    );
        logic [DATA_W-1:0] val;
        val = stored;
        if (fwd_hit && (addr == fwd_addr)) begin
            val = fwd_data;
        end
        if (addr == '0) begin
            val = '0;
        end
        return val;
    endfunction

    logic fwd_en;
`ifdef REGFILE_BYPASS_EN
    assign fwd_en = wr_hit && !rst;
`else
    assign fwd_en = 1'b0;
`endif

    // Zero-latency read ports, optionally forwarding the in-flight write.
    always_comb begin
        bus.rd_data_1 = rd_port(bus.rd_addr_1, regs_q[bus.rd_addr_1],
                                fwd_en, bus.wr_addr, bus.wr_data);
        bus.rd_data_2 = rd_port(bus.rd_addr_2, regs_q[bus.rd_addr_2],
                                fwd_en, bus.wr_addr, bus.wr_data);
        bus.dbg_data  = rd_port(bus.dbg_addr, regs_q[bus.dbg_addr],
                                fwd_en, bus.wr_addr, bus.wr_data);
    end

    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file: vector table plus hand sequences
// for reset, hazard, reset-coincident write and counter wrap.
module tb_mips_reg_file;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mips_reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mips_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [31:0] hz_exp;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle();
        bus.rd_addr_1 = 5'd5;
        bus.rd_addr_2 = 5'd31;
        bus.dbg_addr  = 5'd7;
        #12;
        chk("reset_rd1", bus.rd_data_1, 32'h0);
        chk("reset_rd2", bus.rd_data_2, 32'h0);
        chk("reset_dbg", bus.dbg_data, 32'h0);
        chk("reset_cnt", {16'h0, bus.wr_count}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{1'b1, 5'd1,  32'hDEADBEEF, 5'd1,  5'd0,
                    32'hDEADBEEF, 32'h0, 16'd1};
        vecs[1] = '{1'b1, 5'd2,  32'h00000007, 5'd1,  5'd2,
                    32'hDEADBEEF, 32'h7, 16'd2};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd2,
                    32'h0, 32'h7, 16'd2};
        vecs[3] = '{1'b0, 5'd4,  32'h000000AA, 5'd4,  5'd1,
                    32'h0, 32'hDEADBEEF, 16'd2};
        vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31,
                    32'hCAFEF00D, 32'hCAFEF00D, 16'd3};
        vecs[5] = '{1'b1, 5'd1,  32'h80000001, 5'd1,  5'd31,
                    32'h80000001, 32'hCAFEF00D, 16'd4};
        vecs[6] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd2,
                    32'h12345678, 32'h7, 16'd5};

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.wr_en   = vecs[i].we;
            bus.wr_addr = vecs[i].wa;
            bus.wr_data = vecs[i].wd;
            @(posedge clk);
            #1;
            idle();
            bus.rd_addr_1 = vecs[i].ra1;
            bus.rd_addr_2 = vecs[i].ra2;
            bus.dbg_addr  = vecs[i].ra2;
            #1;
            chk($sformatf("vec%0d_rd1", i), bus.rd_data_1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), bus.rd_data_2, vecs[i].e2);
            chk($sformatf("vec%0d_dbg", i), bus.dbg_data, vecs[i].e2);
            chk($sformatf("vec%0d_cnt", i), {16'h0, bus.wr_count},
                {16'h0, vecs[i].ecnt});
        end

        // Asynchronous reset between edges with r5 loaded
        bus.rd_addr_1 = 5'd5;
        @(negedge clk);
        #2;
        chk("pre_rst_r5", bus.rd_data_1, 32'h12345678);
        rst = 1'b1;
        #1;
        chk("async_rst_r5", bus.rd_data_1, 32'h0);
        chk("async_rst_cnt", {16'h0, bus.wr_count}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Same-cycle hazard on r3
        do_write(5'd3, 32'h11);
        @(negedge clk);
        bus.rd_addr_2 = 5'd3;
        bus.dbg_addr  = 5'd3;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd3;
        bus.wr_data   = 32'h22;
        #1;
`ifdef REGFILE_BYPASS_EN
        hz_exp = 32'h22;
`else
        hz_exp = 32'h11;
`endif
        chk("hazard_pre_rd2", bus.rd_data_2, hz_exp);
        chk("hazard_pre_dbg", bus.dbg_data, hz_exp);
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("hazard_post_rd2", bus.rd_data_2, 32'h22);
        chk("hazard_cnt", {16'h0, bus.wr_count}, 32'h2);

        // A write to $0 is never forwarded
        @(negedge clk);
        bus.rd_addr_1 = 5'd0;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 32'hFFFFFFFF;
        #1;
        chk("zero_nofwd", bus.rd_data_1, 32'h0);
        @(posedge clk);
        #1;
        idle();
        chk("zero_post", bus.rd_data_1, 32'h0);
        chk("zero_cnt", {16'h0, bus.wr_count}, 32'h2);

        // Write edge coinciding with reset is discarded
        @(negedge clk);
        rst           = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd6;
        bus.wr_data   = 32'h66;
        bus.rd_addr_1 = 5'd6;
        #1;
        chk("rst_wr_pre", bus.rd_data_1, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_wr_during", bus.rd_data_1, 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        chk("rst_wr_after", bus.rd_data_1, 32'h0);
        chk("rst_wr_cnt", {16'h0, bus.wr_count}, 32'h0);

        // 65537 writes to r7: counter wraps back to 1
        bus.dbg_addr = 5'd7;
        for (int i = 0; i < 65537; i++) begin
            @(negedge clk);
            bus.wr_en   = 1'b1;
            bus.wr_addr = 5'd7;
            bus.wr_data = 32'(i + 1);
            @(posedge clk);
            #1;
            if (i == 65534) begin
                chk("cnt_ffff", {16'h0, bus.wr_count}, 32'h0000FFFF);
            end
            if (i == 65535) begin
                chk("cnt_wrap0", {16'h0, bus.wr_count}, 32'h0);
            end
        end
        idle();
        #1;
        chk("wrap_cnt", {16'h0, bus.wr_count}, 32'h1);
        chk("wrap_dbg", bus.dbg_data, 32'h00010001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
